// File: rtl/sine_lut.sv
// -----------------------------------------------------------------------------
// sine_lut
//
// One-period sine lookup: 1024 phase points in, 18-bit signed sample out,
// one clock of latency. Only a quarter wave (257 unsigned 17-bit magnitudes)
// is stored. The other three quadrants come from mirroring the index and
// negating the result.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset (0 = in reset, dout forced to 0)
//   addr   in  10   unsigned phase index, 0..1023 spans one full period
//   dout   out 18   registered signed sample, round(131071*sin(2*pi*addr/1024))
//
// Interface timing: there is no valid/ready handshake. Every rising edge
// with reset=1 samples addr, and dout shows that address's sample until
// the next edge. Back-to-back arbitrary addresses are always accepted.
// -----------------------------------------------------------------------------
module sine_lut (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         addr,
  output logic signed [17:0] dout
);

  // pi scaled by 2^60. These are the first 60 fraction bits of pi in hex.
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Builds the quarter-wave table at elaboration time with integer-only
  // fixed-point arithmetic, so the result is a pure constant ROM.
  // Internally x is Q60 in a 128-bit container, so products stay below 2^124.
  // An odd Taylor series to 29th order leaves the truncation error far
  // below one LSB of the 17-bit result. Rounding is half-up, and every
  // value is non-negative.
  function automatic logic [256:0][16:0] build_quarter_table();
    logic [256:0][16:0] t;
    logic [127:0]       x;
    logic [127:0]       x2;
    logic [127:0]       term;
    logic [127:0]       sum;
    t = '0;
    for (int k = 0; k <= 256; k++) begin
      x    = (PI_Q60 * 128'(k)) >> 9;   // pi*k/512
      x2   = (x * x) >> 60;
      term = x;
      sum  = x;
      for (int n = 1; n <= 14; n++) begin
        term = (term * x2) >> 60;
        term = term / 128'((2 * n) * (2 * n + 1));
        if ((n % 2) == 1) sum = sum - term;
        else              sum = sum + term;
      end
      t[k] = 17'((sum * 128'd131071 + (128'd1 << 59)) >> 60);
    end
    return t;
  endfunction

  localparam logic [256:0][16:0] QUARTER = build_quarter_table();

  logic [1:0]          quadrant;
  logic [7:0]          offset;
  logic [8:0]          table_idx;
  logic [16:0]         magnitude;
  logic signed [17:0]  sample;

  assign quadrant = addr[9:8];
  assign offset   = addr[7:0];

  // Quadrants 1 and 3 run the table backwards. The 9-bit index lets
  // offset 0 in those quadrants reach T[256] (the peak).
  always_comb begin
    table_idx = {1'b0, offset};
    if (quadrant[0]) table_idx = 9'd256 - {1'b0, offset};
  end

  assign magnitude = QUARTER[table_idx];

  // Lower half-period: two's complement of the zero-extended magnitude.
  // A zero magnitude negates to zero, so -0 cannot occur.
  always_comb begin
    sample = $signed({1'b0, magnitude});
    if (quadrant[1]) sample = -$signed({1'b0, magnitude});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout <= '0;
    else        dout <= sample;
  end

endmodule

// File: tb/tb_sine_lut.sv
module tb_sine_lut;

  // ---------------------------------------------------------------- clock/reset
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [9:0]         addr = '0;
  logic signed [17:0] dout;

  always #5 clk = ~clk;

  sine_lut dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .dout  (dout)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic signed [17:0] sweep_got [0:1023];

  task automatic check(input string tag, input logic signed [17:0] got,
                       input logic signed [17:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (18'h%05h) expected %0d (18'h%05h)",
                  tag, got, got, exp, exp);
  endtask

  // Golden model: full-period sine in double precision, rounded half away from zero.
  function automatic logic signed [17:0] golden(input int a);
    real v;
    int  r;
    v = 131071.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return 18'(r);
  endfunction

  // ---------------------------------------------------------------- driver
  // Drive one address before an edge, push its expected sample, then pop and
  // compare just after the edge that loads it.
  task automatic step(input logic [9:0] a, input string tag,
                      output logic signed [17:0] got);
    logic [17:0] e;
    @(negedge clk);
    addr = a;
    exp_q.push_back(golden(int'(a)));
    @(posedge clk);
    #1;
    got = dout;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 18'sd1, 18'sd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, dout, $signed(e));
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    logic signed [17:0] g;
    logic signed [17:0] d20, d492, d532;
    int idx [6];
    int val [6];

    // Reset asserted between edges with no clock edge needed.
    #3 reset = 1'b0;
    #1 check("reset_async_initial", dout, 18'sd0);

    // Reset held with addr=20 and the clock running: output stays 0.
    addr = 10'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", dout, 18'sd0);
    end

    // Release reset. The first edge loads the sample for the current address.
    @(negedge clk);
    reset = 1'b1;
    addr  = 10'd20;
    @(posedge clk);
    #1 check("first_after_release", dout, golden(20));

    // Quadrant boundaries and the 45-degree points.
    idx = '{0, 128, 256, 512, 640, 768};
    val = '{0, 92681, 131071, 0, -92681, -131071};
    for (int i = 0; i < 6; i++) begin
      step(10'(idx[i]), "boundary_golden", g);
      check("boundary_const", g, 18'(val[i]));
    end

    // Back-to-back small addresses, then symmetry around addr 20.
    step(10'd20, "b2b_20", g);
    step(10'd30, "b2b_30", g);
    step(10'd70, "b2b_70", g);
    step(10'd20,  "sym_20",  d20);
    step(10'd492, "sym_492", d492);
    step(10'd532, "sym_532", d532);
    check("sym_mirror_20_492", d492, d20);
    check("sym_neg_20_532", d532, -d20);

    // Full sweep with a reset pulse between edges right after the peak.
    for (int i = 0; i < 1024; i++) begin
      step(10'(i), "sweep", g);
      sweep_got[i] = g;
      if (i == 256) begin
        check("peak_before_reset", dout, 18'sd131071);
        #2 reset = 1'b0;
        #1 check("async_clear_mid_sweep", dout, 18'sd0);
        @(negedge clk);
        check("clear_held", dout, 18'sd0);
        reset = 1'b1;
        addr  = 10'd300;
        @(posedge clk);
        #1 check("resume_after_reset", dout, golden(300));
      end
    end
    step(10'd0, "wrap_to_0", g);
    check("wrap_value", g, 18'sd0);

    // Symmetry across the recorded sweep.
    for (int a = 1; a < 256; a++) begin
      check("sweep_sym_mirror", sweep_got[512 - a], sweep_got[a]);
      check("sweep_sym_neg", sweep_got[a + 512], -sweep_got[a]);
    end

    // Random back-to-back addresses.
    for (int i = 0; i < 200; i++) begin
      step(10'($urandom_range(0, 1023)), "random", g);
    end

    // ---------------------------------------------------------------- report
    check("queue_drained", 18'(exp_q.size()), 18'sd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Time limit so the run cannot hang.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule

// File: doc/sine_lut.md
SINE_LUT -- requirements
Module: sine_lut

Interface
REQ-001 The block SHALL have no parameters; depth is fixed at 1024 points per period and output width at 18 bits.
REQ-002 Clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low; 0 = in reset.
REQ-004 addr  input  10  unsigned phase index; one full sine period spans 0..1023.
REQ-005 Dout  output  18  registered signed two's-complement sine sample.

Function
REQ-006 Dout SHALL equal round-half-away-from-zero(131071 * sin(2*pi*addr/1024)), range -131071..+131071; -131072 is never produced.
REQ-007 Latency SHALL be exactly one clock: addr sampled on rising edge N gives its sample on Dout immediately after edge N and held until edge N+1.
REQ-008 A new addr SHALL be accepted every cycle, with no handshake and no stall; back-to-back arbitrary addresses are legal.
REQ-009 Storage SHALL be a quarter-wave table of 257 unsigned 17-bit magnitudes T[k] = round(131071*sin(pi*k/512)), k = 0..256, with T[0]=0 and T[256]=131071.
REQ-010 Quadrant q = addr[9:8] and offset a = addr[7:0] SHALL select the output as follows.
REQ-011 q=0: +T[a].
REQ-012 q=1: +T[256-a], so a=0 reads T[256].
REQ-013 q=2: -T[a].
REQ-014 q=3: -T[256-a].
REQ-015 Negation SHALL be two's complement of the zero-extended 17-bit magnitude to 18 bits; -0 SHALL yield 0.
REQ-016 Quadrant boundary values SHALL be exact: addr 0 -> 0, 256 -> 131071, 512 -> 0, 768 -> -131071 (18'h20001).
REQ-017 Symmetry SHALL hold for all a in 1..255: Dout(addr) = Dout(512-addr) and Dout(addr+512) = -Dout(addr).
REQ-018 addr wrap-around SHALL be natural modulo 1024; the step 1023 -> 0 needs no special handling.
REQ-019 The table SHALL be combinational constant logic (case/ROM) and SHALL contain no writable storage.
REQ-020 The block SHALL contain no state other than the Dout register.

Reset
REQ-021 While reset=0, Dout SHALL be forced to 0 asynchronously, without waiting for a clock edge.
REQ-022 While reset=0, addr SHALL be ignored.
REQ-023 On reset deassertion, the first rising edge with reset=1 SHALL load the sample for the current addr.
REQ-024 Reset asserted between edges SHALL clear Dout immediately.
REQ-025 Deassertion timing SHALL be made safe by the integrator; the block adds no synchronizer.

Verification
REQ-026 Hold reset=0 with addr=20 and the clock running for 5 cycles -> Dout=0 throughout.
REQ-027 Release reset, then apply addr=0, 128, 256, 512, 640, 768 on consecutive edges -> Dout one cycle later = 0, 92681, 131071, 0, -92681, -131071.
REQ-028 Apply addr=20, 30, 70 back to back -> Dout tracks each value with 1-cycle lag and matches REQ-006 exactly; for addr=20 check Dout(20) = Dout(492) = -Dout(532).
REQ-029 Sweep addr 0..1023 then wrap to 0 -> every sample matches the REQ-006 golden model, and the symmetry of REQ-017 holds.
REQ-030 Assert reset=0 mid-sweep between clock edges with Dout=131071 -> Dout=0 before the next edge; after release, the next edge outputs the sample for the current addr.
